uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver.
// Oversamples rx_serial with clk and samples each bit at its centre.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   rx_serial    asynchronous serial line, idles high
//   rx_active    high while a frame is being received (START/DATA/STOP)
//   rx_data      last correctly framed byte, held between frames
//   rx_done      one-cycle pulse when rx_data is updated
//   rx_frame_err one-cycle pulse when the stop bit samples low
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP,
        S_BREAK
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             sync1_q, sync2_q;
    logic             rxs;
    logic             half_end;
    logic             bit_end;

    assign rxs      = sync2_q;
    assign half_end = (cnt_q == CNT_W'(HALF_BIT - 1));
    assign bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // State register, synchroniser and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (half_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A start bit that is high again at its centre was a glitch
                    state_d = rxs ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (rxs) begin
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = S_CLEANUP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CLEANUP: begin
                state_d = S_IDLE;
            end
            S_BREAK: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        rx_active    = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
        rx_data      = data_q;
        rx_done      = done_q;
        rx_frame_err = err_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at a reduced bit rate
// (16 clocks per bit) so the whole sequence stays short.
module tb_uart_rx;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = CPB / 2;
    // Start-bit falling edge to visible done/err: sync(2) + detect(1) + half bit + 9 bits
    localparam int unsigned LAT  = HALF + 9 * CPB + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_serial = 1'b1;
    logic       rx_active;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_frame_err;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ (160000),
        .BAUD_RATE(10000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_serial   (rx_serial),
        .rx_active   (rx_active),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rx_frame_err(rx_frame_err)
    );

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        int unsigned due;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    int unsigned n_done = 0;
    int unsigned n_err = 0;
    logic [7:0]  model_data = 8'h00;
    bit          armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Per-cycle compare against the frame-level model
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (armed) begin
                if (!rst) begin
                    exp_q.delete();
                    model_data = 8'h00;
                    check("reset_done", {31'd0, rx_done}, 32'd0);
                    check("reset_err", {31'd0, rx_frame_err}, 32'd0);
                    check("reset_active", {31'd0, rx_active}, 32'd0);
                end else begin
                    check("done_err_exclusive", {31'd0, rx_done & rx_frame_err}, 32'd0);
                    if (rx_done || rx_frame_err) begin
                        if (rx_done) n_done++;
                        if (rx_frame_err) n_err++;
                        if (exp_q.size() == 0) begin
                            check("unexpected_pulse", {30'd0, rx_done, rx_frame_err}, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("pulse_kind_err", {31'd0, rx_frame_err}, {31'd0, e.is_err});
                            checks++;
                            if (!(cyc + 1 >= e.due && cyc <= e.due + 1)) begin
                                errors++;
                                $display("FAIL pulse_time: pulse at cycle %0d expected %0d +/-1", cyc, e.due);
                            end
                            if (!e.is_err) model_data = e.data;
                        end
                    end else if (exp_q.size() > 0 && cyc > exp_q[0].due + 1) begin
                        e = exp_q.pop_front();
                        check("missed_pulse", {30'd0, rx_done, rx_frame_err},
                              e.is_err ? 32'd1 : 32'd2);
                    end
                    check("rx_data", {24'd0, rx_data}, {24'd0, model_data});
                end
            end
        end
    end

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; a low stop bit leaves the line low afterwards.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        ev_t e;
        rx_serial = 1'b0;
        e.is_err  = !stop;
        e.data    = d;
        e.due     = cyc + LAT;
        exp_q.push_back(e);
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            wait_clks(CPB);
            if (i == 3) check("active_mid_frame", {31'd0, rx_active}, 32'd1);
        end
        rx_serial = stop;
        wait_clks(CPB);
    endtask

    initial begin
        rst       = 1'b0;
        rx_serial = 1'b1;
        wait_clks(100);
        armed = 1'b1;
        wait_clks(2);
        check("por_data", {24'd0, rx_data}, 32'h00);
        rst = 1'b1;

        // Idle after reset
        wait_clks(3 * CPB);
        check("idle_data", {24'd0, rx_data}, 32'h00);
        check("idle_active", {31'd0, rx_active}, 32'd0);

        // Single frame
        send_byte(8'hA5, 1'b1);
        wait_clks(2 * CPB);
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        check("a5_done_count", n_done, 32'd1);
        check("a5_err_count", n_err, 32'd0);
        check("a5_active_after", {31'd0, rx_active}, 32'd0);

        // Back-to-back frames
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        wait_clks(2 * CPB);
        check("b2b_data", {24'd0, rx_data}, 32'h3C);
        check("b2b_done_count", n_done, 32'd4);

        // Short low glitch
        rx_serial = 1'b0;
        wait_clks(3);
        rx_serial = 1'b1;
        check("glitch_active", {31'd0, rx_active}, 32'd1);
        wait_clks(2 * CPB);
        check("glitch_active_after", {31'd0, rx_active}, 32'd0);
        check("glitch_done_count", n_done, 32'd4);
        check("glitch_data", {24'd0, rx_data}, 32'h3C);

        // Framing error with the line held low afterwards
        send_byte(8'h55, 1'b0);
        wait_clks(3 * CPB);
        check("break_active", {31'd0, rx_active}, 32'd0);
        rx_serial = 1'b1;
        wait_clks(2 * CPB);
        check("ferr_count", n_err, 32'd1);
        check("ferr_done_count", n_done, 32'd4);
        check("ferr_data_kept", {24'd0, rx_data}, 32'h3C);
        send_byte(8'hC3, 1'b1);
        wait_clks(2 * CPB);
        check("c3_data", {24'd0, rx_data}, 32'hC3);
        check("c3_done_count", n_done, 32'd5);

        // Reset in the middle of the data bits
        rx_serial = 1'b0;
        wait_clks(5 * CPB);
        check("pre_reset_active", {31'd0, rx_active}, 32'd1);
        rst       = 1'b0;
        rx_serial = 1'b1;
        wait_clks(4);
        check("midreset_data", {24'd0, rx_data}, 32'h00);
        check("midreset_active", {31'd0, rx_active}, 32'd0);
        rst = 1'b1;
        wait_clks(2 * CPB);
        check("midreset_done_count", n_done, 32'd5);
        check("midreset_err_count", n_err, 32'd1);
        send_byte(8'h81, 1'b1);
        wait_clks(2 * CPB);
        check("x81_data", {24'd0, rx_data}, 32'h81);
        check("x81_done_count", n_done, 32'd6);
        check("pending_events", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
